// File: rtl/cpu_param.sv
// Parametrised single-cycle core with a stalling load/store path to data memory.
// Optional shift/rotate opcodes (0D-10) are enabled by defining CPU_SHIFT_EN.
module cpu_param #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3,
    parameter int MEM_AW = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       INSTRUCTION,
    output logic [31:0]       PC,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [MEM_AW-1:0] MEM_ADDRESS,
    output logic [DATA_W-1:0] MEM_WRITEDATA,
    input  logic [DATA_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT
);

    localparam int NREG = 2 ** REG_AW;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_BNE   = 8'h08;
    localparam logic [7:0] OP_LWD   = 8'h09;
    localparam logic [7:0] OP_LWI   = 8'h0A;
    localparam logic [7:0] OP_SWD   = 8'h0B;
    localparam logic [7:0] OP_SWI   = 8'h0C;
`ifdef CPU_SHIFT_EN
    localparam logic [7:0] OP_SLL   = 8'h0D;
    localparam logic [7:0] OP_SRL   = 8'h0E;
    localparam logic [7:0] OP_SRA   = 8'h0F;
    localparam logic [7:0] OP_ROR   = 8'h10;
    localparam logic [31:0] DATA_W_U = DATA_W;
`endif

    typedef enum logic {
        S_EXEC = 1'b0,
        S_MEM  = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [31:0]       pc_r;
    logic [DATA_W-1:0] regs_r [NREG];
    logic              mem_read_r;
    logic              mem_write_r;
    logic [MEM_AW-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [REG_AW-1:0] mem_rd_r;

    logic [7:0]        opcode_s;
    logic [REG_AW-1:0] rd_s;
    logic [REG_AW-1:0] rs1_idx_s;
    logic [REG_AW-1:0] rs2_idx_s;
    logic [DATA_W-1:0] imm_s;
    logic [31:0]       offset_s;
    logic [DATA_W-1:0] rs1_val_s;
    logic [DATA_W-1:0] rs2_val_s;
    logic [DATA_W-1:0] diff_s;
    logic              zero_s;
    logic [DATA_W-1:0] alu_s;
    logic              alu_we_s;
    logic              branch_s;
    logic              is_load_s;
    logic              is_store_s;
    logic [MEM_AW-1:0] mem_addr_s;
    logic [31:0]       pc_plus4_s;
    logic [31:0]       next_pc_s;
    logic              reg_we_s;
    logic [REG_AW-1:0] reg_waddr_s;
    logic [DATA_W-1:0] reg_wdata_s;
    logic              unused_s;

    assign opcode_s   = INSTRUCTION[31:24];
    assign rd_s       = INSTRUCTION[16 +: REG_AW];
    assign rs1_idx_s  = INSTRUCTION[8 +: REG_AW];
    assign rs2_idx_s  = INSTRUCTION[0 +: REG_AW];
    assign imm_s      = DATA_W'($signed(INSTRUCTION[7:0]));
    assign offset_s   = 32'($signed(INSTRUCTION[23:16]));
    assign rs1_val_s  = regs_r[rs1_idx_s];
    assign rs2_val_s  = regs_r[rs2_idx_s];
    assign diff_s     = rs1_val_s - rs2_val_s;
    assign zero_s     = (diff_s == {DATA_W{1'b0}});
    assign pc_plus4_s = pc_r + 32'd4;
    assign next_pc_s  = branch_s ? (pc_plus4_s + (offset_s << 2)) : pc_plus4_s;
    assign unused_s   = ^INSTRUCTION;

`ifdef CPU_SHIFT_EN
    logic [4:0]  shamt_s;
    logic [31:0] rot_s;
    assign shamt_s = INSTRUCTION[4:0];
    assign rot_s   = {27'd0, shamt_s} % DATA_W_U;
`endif

    // Instruction decode and ALU
    always_comb begin
        alu_s      = {DATA_W{1'b0}};
        alu_we_s   = 1'b0;
        branch_s   = 1'b0;
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        mem_addr_s = {MEM_AW{1'b0}};
        case (opcode_s)
            OP_LOADI: begin alu_s = imm_s;                 alu_we_s = 1'b1; end
            OP_MOV:   begin alu_s = rs2_val_s;             alu_we_s = 1'b1; end
            OP_ADD:   begin alu_s = rs1_val_s + rs2_val_s; alu_we_s = 1'b1; end
            OP_SUB:   begin alu_s = diff_s;                alu_we_s = 1'b1; end
            OP_AND:   begin alu_s = rs1_val_s & rs2_val_s; alu_we_s = 1'b1; end
            OP_OR:    begin alu_s = rs1_val_s | rs2_val_s; alu_we_s = 1'b1; end
            OP_J:     branch_s = 1'b1;
            OP_BEQ:   begin alu_s = diff_s; branch_s = zero_s;  end
            OP_BNE:   begin alu_s = diff_s; branch_s = !zero_s; end
            OP_LWD:   begin is_load_s  = 1'b1; mem_addr_s = rs2_val_s[MEM_AW-1:0]; end
            OP_LWI:   begin is_load_s  = 1'b1; mem_addr_s = imm_s[MEM_AW-1:0];     end
            OP_SWD:   begin is_store_s = 1'b1; mem_addr_s = rs2_val_s[MEM_AW-1:0]; end
            OP_SWI:   begin is_store_s = 1'b1; mem_addr_s = imm_s[MEM_AW-1:0];     end
`ifdef CPU_SHIFT_EN
            // Native shifts already give 0 / sign fill for amounts >= DATA_W
            OP_SLL:   begin alu_s = rs1_val_s << shamt_s;           alu_we_s = 1'b1; end
            OP_SRL:   begin alu_s = rs1_val_s >> shamt_s;           alu_we_s = 1'b1; end
            OP_SRA:   begin alu_s = $signed(rs1_val_s) >>> shamt_s; alu_we_s = 1'b1; end
            OP_ROR:   begin
                alu_s    = (rs1_val_s >> rot_s) | (rs1_val_s << (DATA_W_U - rot_s));
                alu_we_s = 1'b1;
            end
`endif
            default:  alu_we_s = 1'b0;
        endcase
    end

    // Next-state and register-file write selection
    always_comb begin
        state_next_s = state_r;
        reg_we_s     = 1'b0;
        reg_waddr_s  = {REG_AW{1'b0}};
        reg_wdata_s  = {DATA_W{1'b0}};
        case (state_r)
            S_EXEC: begin
                if (is_load_s || is_store_s) begin
                    state_next_s = S_MEM;
                end else begin
                    reg_we_s    = alu_we_s;
                    reg_waddr_s = rd_s;
                    reg_wdata_s = alu_s;
                end
            end
            S_MEM: begin
                if (!MEM_BUSYWAIT) begin
                    state_next_s = S_EXEC;
                    reg_we_s     = mem_read_r;
                    reg_waddr_s  = mem_rd_r;
                    reg_wdata_s  = MEM_READDATA;
                end else begin
                    state_next_s = S_MEM;
                end
            end
            default: state_next_s = S_EXEC;
        endcase
    end

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r <= S_EXEC;
        end else begin
            state_r <= state_next_s;
        end
    end

    // PC and registered memory request
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc_r        <= 32'd0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            mem_addr_r  <= {MEM_AW{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            mem_rd_r    <= {REG_AW{1'b0}};
        end else begin
            case (state_r)
                S_EXEC: begin
                    if (is_load_s || is_store_s) begin
                        mem_read_r  <= is_load_s;
                        mem_write_r <= is_store_s;
                        mem_addr_r  <= mem_addr_s;
                        mem_wdata_r <= rs1_val_s;
                        mem_rd_r    <= rd_s;
                    end else begin
                        pc_r <= next_pc_s;
                    end
                end
                S_MEM: begin
                    if (!MEM_BUSYWAIT) begin
                        mem_read_r  <= 1'b0;
                        mem_write_r <= 1'b0;
                        pc_r        <= pc_plus4_s;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                default: begin
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                end
            endcase
        end
    end

    // Register file; register 0 is an ordinary register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (reg_we_s) begin
            regs_r[reg_waddr_s] <= reg_wdata_s;
        end else begin
            regs_r[reg_waddr_s] <= regs_r[reg_waddr_s];
        end
    end

    assign PC            = pc_r;
    assign MEM_READ      = mem_read_r;
    assign MEM_WRITE     = mem_write_r;
    assign MEM_ADDRESS   = mem_addr_r;
    assign MEM_WRITEDATA = mem_wdata_r;

endmodule

// File: doc/cpu_param.md
Name: cpu_param

Overview:
- Parametrised successor to the single-cycle 8-bit core.
- Generalises data width and register count, and adds data-memory load/store with a busy-wait stall handshake.
- Non-memory instructions complete in one cycle; loads and stores use a two-state FSM that stalls the PC until memory completes.
- Sits between the instruction memory (PC/INSTRUCTION) and the data memory (MEM_* bus).

Parameters:
- DATA_W, 8, register/ALU/memory data width (8..32).
- REG_AW, 3, register address bits; 2**REG_AW registers.
- MEM_AW, 8, data memory address bits (<= DATA_W).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  asynchronous active-high reset.
- INSTRUCTION  in  32  instruction at PC.
- PC  out  32  byte address of current instruction.
- MEM_READ  out  1  load request.
- MEM_WRITE  out  1  store request.
- MEM_ADDRESS  out  MEM_AW  data address.
- MEM_WRITEDATA  out  DATA_W  store data.
- MEM_READDATA  in  DATA_W  load data, valid when MEM_BUSYWAIT low.
- MEM_BUSYWAIT  in  1  memory busy; high combinationally while a request is in progress.

Behaviour:
- One clock, CLK. Reset is asynchronous, active-high, named RESET.
- Reset: PC=0, all registers=0, state=S_EXEC, MEM_READ=MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
  - RESET during S_MEM aborts the access immediately; no register write occurs.
- Instruction fields: opcode [31:24], rd/offset [23:16], rs1 [15:8], rs2/imm [7:0].
  - Register indices use the low REG_AW bits of their fields.
  - imm and offset are sign-extended to DATA_W and to 32 bits respectively.
- Opcodes:
  - 00 loadi rd=imm; 01 mov rd=rs2; 02 add; 03 sub (rs1+(-rs2), two's complement); 04 and; 05 or.
  - 06 j; 07 beq; 08 bne.
  - 09 lwd rd=M[rs2]; 0A lwi rd=M[imm]; 0B swd M[rs2]=rs1; 0C swi M[imm]=rs1.
  - Other opcodes are NOPs: no write, PC+4.
- Arithmetic: wraps modulo 2**DATA_W; no flags other than zero (ALU result == 0).
- S_EXEC, non-memory op: register write and PC update happen at the same posedge.
  - Next PC = PC+4, or PC+4+(sext(offset)<<2) when j, when beq with zero=1, or when bne with zero=0.
  - Reads of the register being written return the old value (read combinational, write at posedge).
- S_EXEC, memory op: at posedge, latch address (rs2 or imm, low MEM_AW bits), store data (rs1) and rd; go to S_MEM. PC holds.
- S_MEM:
  - MEM_READ or MEM_WRITE is held high with the latched address and data.
  - Each posedge with MEM_BUSYWAIT=1: stay, PC holds, no writes.
  - First posedge with MEM_BUSYWAIT=0: load writes MEM_READDATA into the latched rd; request drops; PC=PC+4; go to S_EXEC.
  - Memory ops therefore take at least 2 cycles.
- MEM_READ and MEM_WRITE are never both high.
- Register 0 is writable (no hardwired zero).
- PC wraps modulo 2**32.

Optional Feature:
- Macro CPU_SHIFT_EN.
- Defined: opcodes 0D sll, 0E srl, 0F sra, 10 ror.
  - Each computes rd = rs1 shifted by imm[4:0].
  - Shift amounts >= DATA_W give 0 (sll/srl) or sign fill (sra); ror uses amount mod DATA_W.
- Undefined: 0D-10 are NOPs.

Test Plan:
- Reset: assert RESET mid-S_MEM (MEM_READ=1) -> MEM_READ falls immediately, PC=0, all registers=0 after release.
- ALU: loadi r1,5; loadi r2,3; sub r3,r1,r2; add r4,r3,r3 -> r3=2, r4=4, one instruction per cycle, PC 0,4,8,12,16.
- Branch: r1=7, r2=7, beq offset=+2 at PC=8 -> next PC=20; bne same regs -> PC=12; j offset=-3 at PC=20 -> PC=12.
- Load stall: lwi r5,0x10 with memory holding BUSYWAIT for 3 cycles then returning 0xA5 -> r5=0xA5, PC holds for 4 cycles, then advances by 4.
- Store: swd r1->M[r2], r1=0x3C, r2=0x20, BUSYWAIT=1 for 2 cycles -> MEM_WRITE=1, MEM_ADDRESS=0x20, MEM_WRITEDATA=0x3C stable throughout; no register change.
- Width and optional feature: DATA_W=16, REG_AW=4, CPU_SHIFT_EN defined; loadi r15,-1 (0xFFFF); sra r14,r15,imm=4 -> 0xFFFF; srl -> 0x0FFF. Without the macro, r14 is unchanged.
